// File: rtl/fc_pkg.sv
// Shared defaults and FSM state encoding for the dense-layer class sequencer.
package fc_pkg;
    localparam int NUM_CLASSES    = 10;
    localparam int SCORE_W        = 46;
    localparam int CLASS_W        = $clog2(NUM_CLASSES);
    localparam int TIMEOUT_CYCLES = 2047;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/score_max_tracker.sv
// Running signed argmax over captured class scores; ties keep the lowest index.
module score_max_tracker #(
    parameter int CLASS_W = 4,
    parameter int SCORE_W = 46
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      capture,
    input  logic [CLASS_W-1:0]        index,
    input  logic signed [SCORE_W-1:0] score,
    output logic [CLASS_W-1:0]        label,
    output logic signed [SCORE_W-1:0] max_score
);
    // Index 0 always wins so stale scores from an earlier pass never compete.
    logic take;
    assign take = capture && ((index == '0) || (score > max_score));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            label     <= '0;
            max_score <= '0;
        end else if (clear) begin
            label     <= '0;
            max_score <= '0;
        end else if (take) begin
            label     <= index;
            max_score <= score;
        end
    end
endmodule

// File: rtl/fc_class_sequencer.sv
// Steps the dense/softmax unit through every class, one enable pulse per class,
// and reports the argmax label with a per-class completion timeout.
import fc_pkg::*;

module fc_class_sequencer #(
    parameter int NUM_CLASSES    = fc_pkg::NUM_CLASSES,
    parameter int SCORE_W        = fc_pkg::SCORE_W,
    parameter int TIMEOUT_CYCLES = fc_pkg::TIMEOUT_CYCLES,
    localparam int CLASS_W       = $clog2(NUM_CLASSES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      fc_enable,
    output logic [CLASS_W-1:0]        fc_class,
    input  logic signed [SCORE_W-1:0] fc_score,
    input  logic                      fc_done,
    output logic [CLASS_W-1:0]        label,
    output logic signed [SCORE_W-1:0] max_score,
    output logic                      label_valid,
    output logic                      timeout_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]      T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CLASS_W-1:0] K_LAST = CLASS_W'(NUM_CLASSES - 1);

    state_t        state;
    logic [TW-1:0] tcnt;
    logic          clear, capture;

    assign clear   = (state == IDLE) && start;
    assign capture = (state == WAIT) && fc_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fc_class    <= '0;
            tcnt        <= '0;
            busy        <= 1'b0;
            fc_enable   <= 1'b0;
            label_valid <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            label_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state       <= WAIT;
                    fc_class    <= '0;
                    tcnt        <= '0;
                    busy        <= 1'b1;
                    fc_enable   <= 1'b1;
                    timeout_err <= 1'b0;
                end
                WAIT: begin
                    if (fc_done) begin
                        state     <= GAP;
                        fc_enable <= 1'b0;
                    end else if (tcnt == T_LAST) begin
                        // Abandon the pass; the label keeps what was captured so far.
                        state       <= DONE;
                        fc_enable   <= 1'b0;
                        timeout_err <= 1'b1;
                        label_valid <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                GAP: begin
                    if (fc_class == K_LAST) begin
                        state       <= DONE;
                        label_valid <= 1'b1;
                    end else begin
                        state     <= WAIT;
                        fc_class  <= fc_class + 1'b1;
                        tcnt      <= '0;
                        fc_enable <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    score_max_tracker #(
        .CLASS_W (CLASS_W),
        .SCORE_W (SCORE_W)
    ) u_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .capture   (capture),
        .index     (fc_class),
        .score     (fc_score),
        .label     (label),
        .max_score (max_score)
    );
endmodule

// File: tb/tb_fc_class_sequencer.sv
// Directed bench: a behavioural dense unit with programmable done latency feeds
// scores per class; table vectors plus timeout and mid-pass reset sequences.
module tb_fc_class_sequencer;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               busy, fc_enable, fc_done, label_valid, timeout_err;
    logic [3:0]         fc_class, label;
    logic signed [45:0] fc_score, max_score;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fc_class_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .fc_enable   (fc_enable),
        .fc_class    (fc_class),
        .fc_score    (fc_score),
        .fc_done     (fc_done),
        .label       (label),
        .max_score   (max_score),
        .label_valid (label_valid),
        .timeout_err (timeout_err)
    );

    // Dense unit model: done rises d_lat edges after it sees enable, held while enabled.
    int              d_lat = 1;
    int              dcnt  = 0;
    logic [9:0]      done_mask = '1;
    logic [9:0][45:0] sc;

    always @(posedge clk) begin
        if (!fc_enable) dcnt <= 0;
        else if (dcnt < d_lat) dcnt <= dcnt + 1;
    end

    always_comb begin
        fc_done  = 1'b0;
        fc_score = '0;
        if (fc_class < 4'd10) begin
            fc_done  = fc_enable && (dcnt >= d_lat) && done_mask[fc_class];
            fc_score = sc[fc_class];
        end
    end

    typedef struct {
        int               d;
        logic [9:0][45:0] s;
        logic [3:0]       lbl;
        longint           mx;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input int d, input int a [10], input int lbl, input longint mx);
        vt[idx].d = d;
        for (int j = 0; j < 10; j++) vt[idx].s[j] = 46'(a[j]);
        vt[idx].lbl = 4'(lbl);
        vt[idx].mx  = mx;
    endtask

    // Runs one pass from a start pulse and observes enable/class stepping until label_valid.
    task automatic run_pass(input int repulse, output int lat, output int nrise, output int first_en,
                            output int last_run, output bit cls_ok, output bit gap_ok);
        int cnt;
        int gap;
        int run;
        bit prev;
        lat = -1; nrise = 0; first_en = -1; last_run = 0; cls_ok = 1; gap_ok = 1;
        prev = 0; gap = 0; run = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; cnt = 1;
        while (cnt < 5000) begin
            if (label_valid) begin
                lat = cnt;
                break;
            end
            if (fc_enable) begin
                if (!prev) begin
                    if (first_en < 0) first_en = cnt;
                    if (nrise > 0 && gap != 1) gap_ok = 0;
                    if (fc_class != 4'(nrise)) cls_ok = 0;
                    nrise++;
                    run = 0;
                    gap = 0;
                end
                run++;
                last_run = run;
            end else begin
                gap++;
            end
            prev  = fc_enable;
            start = (cnt == repulse);
            @(negedge clk); cnt++;
        end
        start = 1'b0;
        if (lat < 0) begin
            errors++;
            $display("FAIL pass_timeout: no label_valid within bound");
        end
    endtask

    task automatic load(input int idx);
        sc    = vt[idx].s;
        d_lat = vt[idx].d;
    endtask

    int  lat, nrise, first_en, last_run;
    bit  cls_ok, gap_ok;

    initial begin
        int a [10];
        bit seen_lv;
        rst_n = 1'b0;
        start = 1'b0;
        sc    = '0;

        a = '{5, -3, 100, 7, 100, 0, 1, 2, 3, 4};          set_vec(0, 1, a, 2, 100);
        a = '{-9, -10, -11, -12, -13, -14, -2, -16, -17, -18}; set_vec(1, 1, a, 6, -2);
        a = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};               set_vec(2, 1, a, 9, (64'sd1 <<< 45) - 1);
        vt[2].s[0] = {1'b1, 45'b0};
        vt[2].s[9] = {1'b0, {45{1'b1}}};
        set_vec(3, 1, a, 0, (64'sd1 <<< 45) - 1);
        vt[3].s[0] = {1'b0, {45{1'b1}}};
        a = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7};               set_vec(4, 0, a, 0, 7);
        a = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};               set_vec(5, 3, a, 9, 9);

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_fc_enable", fc_enable, 0);
        chk("rst_fc_class", fc_class, 0);
        chk("rst_label", label, 0);
        chk("rst_max_score", max_score, 0);
        chk("rst_label_valid", label_valid, 0);
        chk("rst_timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            load(i);
            run_pass(0, lat, nrise, first_en, last_run, cls_ok, gap_ok);
            chk($sformatf("v%0d_latency", i), lat, 10 * (vt[i].d + 2) + 1);
            chk($sformatf("v%0d_label", i), label, vt[i].lbl);
            chk($sformatf("v%0d_max_score", i), max_score, vt[i].mx);
            chk($sformatf("v%0d_timeout_err", i), timeout_err, 0);
            chk($sformatf("v%0d_first_enable", i), first_en, 1);
            chk($sformatf("v%0d_classes", i), nrise, 10);
            chk($sformatf("v%0d_class_step", i), cls_ok, 1);
            chk($sformatf("v%0d_gap_one", i), gap_ok, 1);
            chk($sformatf("v%0d_busy_in_done", i), busy, 1);
            @(negedge clk);
            chk($sformatf("v%0d_busy_after", i), busy, 0);
            chk($sformatf("v%0d_lv_pulse", i), label_valid, 0);
        end

        // Outputs hold after the pass.
        repeat (5) @(negedge clk);
        chk("hold_label", label, 9);
        chk("hold_max_score", max_score, 9);

        // Start re-pulsed during WAIT of class 1 must not disturb the pass.
        load(0);
        run_pass(4, lat, nrise, first_en, last_run, cls_ok, gap_ok);
        chk("repulse_latency", lat, 31);
        chk("repulse_classes", nrise, 10);
        chk("repulse_label", label, 2);
        @(negedge clk);
        chk("repulse_idle", busy, 0);

        // Class 0 never completes: nothing captured, outputs forced to zero.
        load(1);
        done_mask = 10'b11_1111_1110;
        run_pass(0, lat, nrise, first_en, last_run, cls_ok, gap_ok);
        chk("to0_latency", lat, 2048);
        chk("to0_err", timeout_err, 1);
        chk("to0_label", label, 0);
        chk("to0_max_score", max_score, 0);
        chk("to0_wait_cycles", last_run, 2047);

        // Class 3 never completes: label reflects classes 0-2 only.
        done_mask = 10'b11_1111_0111;
        run_pass(0, lat, nrise, first_en, last_run, cls_ok, gap_ok);
        chk("to3_latency", lat, 2057);
        chk("to3_err", timeout_err, 1);
        chk("to3_label", label, 0);
        chk("to3_max_score", max_score, -9);
        chk("to3_classes", nrise, 4);
        chk("to3_wait_cycles", last_run, 2047);
        repeat (4) @(negedge clk);
        chk("to3_err_sticky", timeout_err, 1);
        done_mask = '1;

        // Clean pass clears the sticky error.
        load(1);
        run_pass(0, lat, nrise, first_en, last_run, cls_ok, gap_ok);
        chk("clr_err", timeout_err, 0);
        chk("clr_label", label, 6);

        // Reset during class 5 aborts the pass.
        load(0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (fc_enable && fc_class == 4'd5) break;
            @(negedge clk);
        end
        chk("mid_reached_class5", fc_class, 5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_fc_enable", fc_enable, 0);
        chk("mid_rst_fc_class", fc_class, 0);
        chk("mid_rst_label", label, 0);
        chk("mid_rst_max_score", max_score, 0);
        chk("mid_rst_timeout_err", timeout_err, 0);
        seen_lv = 0;
        repeat (3) begin
            @(negedge clk);
            if (label_valid) seen_lv = 1;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (label_valid || busy) seen_lv = 1;
        end
        chk("mid_no_activity", seen_lv, 0);
        run_pass(0, lat, nrise, first_en, last_run, cls_ok, gap_ok);
        chk("post_rst_latency", lat, 31);
        chk("post_rst_label", label, 2);
        chk("post_rst_max_score", max_score, 100);
        chk("post_rst_class_step", cls_ok, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fc_class_sequencer.md
FC_CLASS_SEQUENCER -- requirements
Module: fc_class_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_CLASSES, default 10, giving the number of output classes scored per inference.
REQ-002 The block SHALL have parameter SCORE_W, default 46, giving the signed width of a class score from the dense unit.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 2047, giving the maximum cycles to wait for the dense unit's done.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: request one full classification pass.
REQ-007 The block SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until the block returns to IDLE.
REQ-008 The block SHALL have port fc_enable, output, 1 bit: enable to the dense/softmax unit; high means compute, low means clear.
REQ-009 The block SHALL have port fc_class, output, CLASS_W=$clog2(NUM_CLASSES) bits: class index selecting the weight/bias set.
REQ-010 The block SHALL have port fc_score, input, SCORE_W bits signed: dense-unit result.
REQ-011 The block SHALL have port fc_done, input, 1 bit: dense-unit completion flag, level-held while fc_enable is high.
REQ-012 The block SHALL have port label, output, CLASS_W bits: argmax class index.
REQ-013 The block SHALL have port max_score, output, SCORE_W bits signed: winning score.
REQ-014 The block SHALL have port label_valid, output, 1 bit: one-cycle pulse when the pass completes.
REQ-015 The block SHALL have port timeout_err, output, 1 bit: sticky flag, set when a class timed out.

Function
REQ-016 States SHALL be IDLE, WAIT, GAP, DONE.
- IDLE: start=1 -> WAIT; class counter k=0; label, max_score and timeout_err cleared.
- WAIT: fc_enable=1, fc_class=k, timeout counter increments.
- WAIT, fc_done=1: capture fc_score -> GAP.
- WAIT, counter reaches TIMEOUT_CYCLES with fc_done=0: set timeout_err -> DONE.
- GAP: fc_enable=0 for exactly one cycle; k==NUM_CLASSES-1 -> DONE, else k+1 and -> WAIT.
- DONE: label_valid=1 for one cycle -> IDLE.
REQ-017 fc_enable SHALL rise exactly one cycle after start is sampled high in IDLE.
REQ-018 On capture, if k==0 or fc_score > max_score (signed, strict), then max_score<=fc_score and label<=k; ties SHALL keep the lowest index.
REQ-019 start SHALL be ignored in WAIT, GAP and DONE.
REQ-020 fc_done SHALL be ignored in IDLE, GAP and DONE.
REQ-021 The timeout counter SHALL clear on every entry to WAIT.
REQ-022 label and max_score SHALL hold their last values until the next accepted start.
REQ-023 The pass latency for a dense unit with done latency D SHALL be NUM_CLASSES*(D+2)+1 cycles from start sampled to the label_valid pulse.
REQ-024 On timeout, label and max_score SHALL reflect only the classes already captured; if none were captured, both SHALL be 0.

Reset
REQ-025 On rst_n=0, asynchronously: state=IDLE, k=0, busy=0, fc_enable=0, fc_class=0, label=0, max_score=0, label_valid=0, timeout_err=0.
REQ-026 Reset mid-pass SHALL abort the pass with no label_valid pulse; after release the block SHALL wait for a new start.

Structure
REQ-027 Package fc_pkg SHALL hold NUM_CLASSES, SCORE_W, CLASS_W, TIMEOUT_CYCLES defaults and the state enum.
REQ-028 The signed compare and capture SHALL be a sub-module score_max_tracker (inputs: clear, capture, index, score; outputs: label, max_score).

Verification
REQ-029 Scores 5,-3,100,7,100,0,1,2,3,4 with D=1 -> label=2, max_score=100, label_valid at cycle 31, timeout_err=0.
REQ-030 All scores negative, -9..-18, with class 6=-2 -> label=6, max_score=-2.
REQ-031 Class 0=-2^45, class 9=2^45-1, others 0 -> label=9; class 0 alone at 2^45-1 -> label=0.
REQ-032 fc_done never asserted for class 3 -> timeout_err=1 after 2047 WAIT cycles, label_valid pulses, label reflects classes 0-2.
REQ-033 start re-pulsed during WAIT is ignored; rst_n low during class 5 -> all outputs 0, no label_valid, and a new start runs a clean pass.
REQ-034 The bench SHALL check that fc_enable is low for exactly one cycle between consecutive classes and that fc_class steps 0..9.
